// File: rtl/alu_seq_exec_pkg.sv
// Shared definitions for the sequential ALU execution unit: op codes, FSM states
// and shift kinds. The op codes must match the ALU decoder's encoding.
package alu_seq_exec_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shift_kind_t;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    function automatic shift_kind_t shift_kind_of(input logic [3:0] code);
        case (code)
            ALU_SRL: return SH_RL;
            ALU_SRA: return SH_RA;
            default: return SH_LL;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the decode stage, the execution unit and writeback.
// Signal names follow the core's existing datapath naming.
interface alu_seq_exec_if
    import alu_seq_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    logic            illegal_op;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, illegal_op
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, illegal_op
    );

endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: load a value and a count, then it shifts once per
// cycle until the count runs out. result_next is the value after the current step.
module alu_serial_shifter
    import alu_seq_exec_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  shift_kind_t        kind,
    input  logic [XLEN-1:0]    value,
    input  logic [SHAMT_W-1:0] amount,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result_next
);

    logic [XLEN-1:0]    shreg;
    logic [SHAMT_W-1:0] count;
    shift_kind_t        kind_q;

    assign busy = (count != '0);
    // done marks the step whose update brings the count to zero.
    assign done = (count == SHAMT_W'(1));

    always_comb begin
        case (kind_q)
            SH_LL:   result_next = {shreg[XLEN-2:0], 1'b0};
            SH_RL:   result_next = {1'b0, shreg[XLEN-1:1]};
            SH_RA:   result_next = {shreg[XLEN-1], shreg[XLEN-1:1]};
            default: result_next = shreg;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
            count  <= '0;
            kind_q <= SH_LL;
        end else if (load) begin
            shreg  <= value;
            count  <= amount;
            kind_q <= kind;
        end else if (busy) begin
            shreg  <= result_next;
            count  <= count - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execution unit: single-cycle logic/arithmetic/compare ops,
// serial shifts, valid/ready handshakes on both the request and result sides.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    alu_seq_exec_if.slave bus
);

    state_t             state, state_next;
    logic [XLEN-1:0]    op_result, result_d, result_q, sh_next;
    logic               op_illegal, illegal_d, illegal_q, zero_q;
    logic               capture, sh_load, sh_busy, sh_done, accept;
    logic [SHAMT_W-1:0] shamt;

    assign shamt  = bus.SrcB[SHAMT_W-1:0];
    assign accept = bus.in_valid && (state == S_IDLE);

    // Shift codes yield SrcA here: that is the zero-shamt result.
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (bus.ALUControl)
            ALU_ADD:  op_result = bus.SrcA + bus.SrcB;
            ALU_SUB:  op_result = bus.SrcA - bus.SrcB;
            ALU_AND:  op_result = bus.SrcA & bus.SrcB;
            ALU_OR:   op_result = bus.SrcA | bus.SrcB;
            ALU_XOR:  op_result = bus.SrcA ^ bus.SrcB;
            ALU_SLT:  op_result = {{(XLEN-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            ALU_SLTU: op_result = {{(XLEN-1){1'b0}}, bus.SrcA < bus.SrcB};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  op_result = bus.SrcA;
            default:  op_illegal = 1'b1;
        endcase
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (sh_load),
        .kind        (shift_kind_of(bus.ALUControl)),
        .value       (bus.SrcA),
        .amount      (shamt),
        .busy        (sh_busy),
        .done        (sh_done),
        .result_next (sh_next)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        sh_load    = 1'b0;
        result_d   = op_result;
        illegal_d  = op_illegal;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift_op(bus.ALUControl) && (shamt != '0)) begin
                        sh_load    = 1'b1;
                        state_next = S_SHIFT;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (sh_done) begin
                    capture    = 1'b1;
                    result_d   = sh_next;
                    illegal_d  = 1'b0;
                    state_next = S_DONE;
                end else if (!sh_busy) begin
                    state_next = S_IDLE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Result, Zero and illegal_op only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (capture) begin
            result_q  <= result_d;
            zero_q    <= (result_d == '0);
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready   = (state == S_IDLE);
    assign bus.out_valid  = (state == S_DONE);
    assign bus.ALUResult  = result_q;
    assign bus.Zero       = zero_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec with hand-computed results,
// latencies, backpressure and reset scenarios.
module tb_alu_seq_exec;
    import alu_seq_exec_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq_exec_if #(.XLEN(32)) bus ();

    alu_seq_exec #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid   = 1'b1;
        bus.ALUControl = code;
        bus.SrcA       = a;
        bus.SrcB       = b;
        tick();
        bus.in_valid   = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid, bounded.
    task automatic wait_done(output int lat, output logic ready_seen);
        lat        = 1;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < 64) begin
            if (bus.in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_lat);
        int   lat;
        logic ready_seen;
        issue(code, a, b);
        wait_done(lat, ready_seen);
        check({tag, "_lat"},     lat, exp_lat);
        check({tag, "_busy_rdy"}, {31'b0, ready_seen}, 32'd0);
        check({tag, "_res"},     bus.ALUResult, exp_res);
        check({tag, "_zero"},    {31'b0, bus.Zero}, {31'b0, exp_res == 32'd0});
        check({tag, "_ill"},     {31'b0, bus.illegal_op}, {31'b0, exp_ill});
        check({tag, "_done_rdy"}, {31'b0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_rdy_back"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic ready_seen;

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ALUControl = ALU_ADD;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        tick();
        tick();
        check("rst_in_ready",  {31'b0, bus.in_ready},   32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid},  32'd0);
        check("rst_result",    bus.ALUResult,           32'd0);
        check("rst_zero",      {31'b0, bus.Zero},       32'd1);
        check("rst_illegal",   {31'b0, bus.illegal_op}, 32'd0);
        reset = 1'b0;

        run_op("add_wrap",  ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
        run_op("sub_zero",  ALU_SUB,  32'd5,         32'd5,         32'd0,         1'b0, 1);
        run_op("slt_neg",   ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1,         1'b0, 1);
        run_op("sltu_neg",  ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0,         1'b0, 1);
        run_op("and",       ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1);
        run_op("xor",       ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
        run_op("sra_31",    ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 32);
        run_op("srl_31",    ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32);
        run_op("sll_hi",    ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 2);
        run_op("sll_zero",  ALU_SLL,  32'hABCD_1234, 32'h0000_0020, 32'hABCD_1234, 1'b0, 1);
        run_op("sra_pos",   ALU_SRA,  32'h4000_0000, 32'h0000_0004, 32'h0400_0000, 1'b0, 5);
        run_op("sra_neg",   ALU_SRA,  32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 1'b0, 5);
        run_op("illegal_f", 4'b1111,  32'h1234_5678, 32'h1111_1111, 32'd0,         1'b1, 1);
        run_op("illegal_4", 4'b0100,  32'h0000_0001, 32'h0000_0002, 32'd0,         1'b1, 1);

        // Backpressure: result held while out_ready is low and new requests are ignored.
        issue(ALU_OR, 32'h0000_F0F0, 32'h0000_0F0F);
        wait_done(lat, ready_seen);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid   = 1'b1;
            bus.ALUControl = ALU_AND;
            bus.SrcA       = 32'h0000_0000;
            bus.SrcB       = 32'h0000_1000 + i;
            tick();
            check("bp_valid",  {31'b0, bus.out_valid}, 32'd1);
            check("bp_ready",  {31'b0, bus.in_ready},  32'd0);
            check("bp_result", bus.ALUResult,          32'h0000_FFFF);
            check("bp_zero",   {31'b0, bus.Zero},      32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_vld_drop", {31'b0, bus.out_valid}, 32'd0);
        check("bp_rdy_back", {31'b0, bus.in_ready},  32'd1);
        tick();
        check("bp_no_stray", {31'b0, bus.out_valid}, 32'd0);

        // Reset on the third cycle of a 10-step srl discards the pending result.
        issue(ALU_SRL, 32'hFFFF_0000, 32'd10);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid",  {31'b0, bus.out_valid},  32'd0);
        check("midrst_ready",  {31'b0, bus.in_ready},   32'd1);
        check("midrst_result", bus.ALUResult,           32'd0);
        check("midrst_zero",   {31'b0, bus.Zero},       32'd1);
        check("midrst_ill",    {31'b0, bus.illegal_op}, 32'd0);
        tick();
        check("midrst_stay",   {31'b0, bus.out_valid},  32'd0);
        run_op("post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        // Reset and request on the same edge: the request is dropped.
        reset          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ALUControl = ALU_ADD;
        bus.SrcA       = 32'd7;
        bus.SrcB       = 32'd8;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("rst_win_valid",  {31'b0, bus.out_valid}, 32'd0);
        check("rst_win_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_win_result", bus.ALUResult,          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU decoder and executes the operation on two operands.
- Logic/arithmetic/compare ops complete in one cycle. Shifts run on a serial 1-bit-per-cycle shifter to save area.
- Sits between the decode/control stage and writeback. Has valid/ready handshakes on both sides so it can be used in a multi-cycle or pipelined core variant.

Parameters:
- XLEN, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 XLEN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request (IDLE)
- ALUControl  in  4  operation code (encoding below)
- SrcA  in  XLEN  operand A
- SrcB  in  XLEN  operand B; SrcB[SHAMT_W-1:0] is shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALUResult  out  XLEN  result
- Zero  out  1  ALUResult == 0
- illegal_op  out  1  code not in table; qualified by out_valid

Behaviour:
- Encoding:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0101 slt (signed); 0110 xor
  - 0111 sll; 1000 srl; 1001 sra; 1100 sltu
  - All other codes are illegal.
- Reset: state=IDLE, in_ready=1, out_valid=0, ALUResult=0, Zero=1, illegal_op=0, internal shift count=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch the code and operands.
    - Non-shift op: compute the result, register it, go to DONE.
    - Shift op with shamt=0: result=SrcA, go to DONE.
    - Shift op with shamt>0: load shift reg=SrcA and count=shamt, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle shift by 1 and decrement count.
    - sll fills 0 at the LSB; srl fills 0 at the MSB; sra replicates the MSB.
    - When count reaches 0 after the update, transfer to ALUResult and go to DONE.
  - DONE: out_valid=1, outputs held stable. When out_ready=1, go to IDLE (out_valid falls next cycle).
- Latency, accept edge to out_valid:
  - 1 cycle for non-shift ops and shamt=0.
  - 1+shamt cycles for shifts, max 32 at shamt=31.
- Throughput: one op in flight. There is no overlap; the next accept happens at the earliest 1 cycle after the DONE handshake.
- Arithmetic:
  - add/sub wrap modulo 2^XLEN, with no overflow flag.
  - slt/sltu produce {XLEN-1 zeros, bit}.
  - Only the low SHAMT_W bits of SrcB are used for shifts; upper bits are ignored.
- Illegal code: result=0, Zero=1, illegal_op=1, 1-cycle latency. This is not a hang.
- Zero and illegal_op are registered alongside ALUResult and change only when entering DONE.
- Inputs are sampled only on the accept edge (in_valid & in_ready). Changes during SHIFT/DONE have no effect.
- out_ready held high in DONE: the handshake completes in the first DONE cycle. out_ready asserted outside DONE is ignored.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values on the next edge. The pending result is discarded.
- Reset and in_valid in the same cycle: reset wins and the request is not accepted.

Decomposition:
- Shared package:
  - ALU op code constants (ALU_ADD..ALU_SLTU), which must be the same constants the ALU decoder uses.
  - FSM state enum (S_IDLE, S_SHIFT, S_DONE).
  - XLEN default.
- One natural sub-module: alu_serial_shifter. It holds the shift register and down-counter, with load/busy/done and a direction/arith select.
- Combinational single-cycle ops stay in the top-level module.

Test Plan:
- add 0x7FFFFFFF + 0x00000001 -> ALUResult=0x80000000, Zero=0, out_valid 1 cycle after accept.
- sub 5-5 -> ALUResult=0, Zero=1. slt 0xFFFFFFFF vs 1 -> 1. sltu on the same operands -> 0.
- sra SrcA=0x80000000, SrcB=0x0000001F -> 0xFFFFFFFF after exactly 32 cycles, in_ready=0 throughout. srl on the same operands -> 0x00000001. sll 0x1 by SrcB=0x21 (shamt=1) -> 0x2 after 2 cycles.
- Shift with shamt=0 (sll 0xABCD1234, SrcB=0x20) -> 0xABCD1234 after 1 cycle. Illegal code 1111 -> ALUResult=0, illegal_op=1, after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0, with new in_valid pulses ignored. Then out_ready=1 -> out_valid drops next cycle and in_ready=1.
- Reset asserted on the 3rd cycle of a 10-cycle srl -> next cycle state=IDLE, out_valid=0, ALUResult=0. A following add 2+3 -> 5 with normal latency.
